// File: rtl/vsync_pkg.sv
// Shared types and default constants for the V_SYNC front-end.
package vsync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } vsync_state_e;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_FILTER_LEN     = 4;
    localparam int DEF_PERIOD_W       = 24;
    localparam int DEF_MIN_PERIOD     = 160000;
    localparam int DEF_TIMEOUT_CYCLES = 16000000;
    localparam int FRAME_CNT_W        = 16;

endpackage

// File: rtl/vsync_conditioner_sync_filter.sv
// Synchronizer chain plus stability counter; the filtered level only follows
// the synced input after FILTER_LEN consecutive samples that differ from it.
module sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic armed_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic [CNT_W-1:0]       stab_cnt_q;
    logic                   level_q;
    logic                   armed_q;
    logic                   synced;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign level_o = level_q;
    assign armed_o = armed_q;

    // armed_q is set once a real low sample has passed the chain, so a line
    // that is already high when reset releases never reports a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            vld_q      <= '0;
            stab_cnt_q <= '0;
            level_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            if (vld_q[SYNC_STAGES-1] && !synced) begin
                armed_q <= 1'b1;
            end
            if (synced == level_q) begin
                stab_cnt_q <= '0;
            end else if (stab_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_q    <= synced;
                stab_cnt_q <= '0;
            end else begin
                stab_cnt_q <= stab_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vsync_conditioner.sv
// Conditions the camera V_SYNC into a clean frame strobe with parity, period
// measurement, runt rejection and loss-of-sync detection.
module vsync_conditioner
    import vsync_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int PERIOD_W       = DEF_PERIOD_W,
    parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   v_sync_i,
    output logic                   frame_stb_o,
    output logic                   frame_parity_o,
    output logic [PERIOD_W-1:0]    frame_period_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   sync_locked_o,
    output logic                   sync_lost_o,
    output logic                   runt_err_o
);

    localparam logic [PERIOD_W:0]   ONE_W   = (PERIOD_W + 1)'(1);
    localparam logic [PERIOD_W:0]   MIN_P   = (PERIOD_W + 1)'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT_CYCLES - 1);

    logic                level;
    logic                armed;
    logic                level_prev_q;
    logic                rise_q;
    vsync_state_e        state_q;
    logic [PERIOD_W-1:0] period_cnt_q;
    logic [PERIOD_W:0]   cnt_plus1;
    logic                early;
    logic                timeout;

    sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (v_sync_i),
        .level_o (level),
        .armed_o (armed)
    );

    assign cnt_plus1 = {1'b0, period_cnt_q} + ONE_W;
    assign early     = cnt_plus1 < MIN_P;
    assign timeout   = period_cnt_q == TO_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q   <= 1'b0;
            rise_q         <= 1'b0;
            state_q        <= ST_IDLE;
            period_cnt_q   <= '0;
            frame_stb_o    <= 1'b0;
            frame_parity_o <= 1'b0;
            frame_period_o <= '0;
            frame_cnt_o    <= '0;
            sync_locked_o  <= 1'b0;
            sync_lost_o    <= 1'b0;
            runt_err_o     <= 1'b0;
        end else begin
            level_prev_q <= level;
            rise_q       <= level & ~level_prev_q & armed;
            frame_stb_o  <= 1'b0;
            runt_err_o   <= 1'b0;
            if (!(&period_cnt_q)) begin
                period_cnt_q <= cnt_plus1[PERIOD_W-1:0];
            end
            case (state_q)
                ST_IDLE: begin
                    if (rise_q) begin
                        frame_stb_o    <= 1'b1;
                        frame_parity_o <= ~frame_parity_o;
                        frame_cnt_o    <= frame_cnt_o + 1'b1;
                        sync_lost_o    <= 1'b0;
                        period_cnt_q   <= '0;
                        state_q        <= ST_ACQUIRE;
                        sync_locked_o  <= 1'b0;
                    end
                end
                ST_ACQUIRE, ST_LOCKED: begin
                    // An accepted edge outranks a timeout landing on the same cycle.
                    if (rise_q && !early) begin
                        frame_stb_o    <= 1'b1;
                        frame_parity_o <= ~frame_parity_o;
                        frame_cnt_o    <= frame_cnt_o + 1'b1;
                        frame_period_o <= cnt_plus1[PERIOD_W-1:0];
                        sync_lost_o    <= 1'b0;
                        period_cnt_q   <= '0;
                        state_q        <= ST_LOCKED;
                        sync_locked_o  <= 1'b1;
                    end else begin
                        if (rise_q) begin
                            runt_err_o <= 1'b1;
                        end
                        if (timeout) begin
                            sync_lost_o    <= 1'b1;
                            frame_parity_o <= 1'b0;
                            frame_cnt_o    <= '0;
                            state_q        <= ST_IDLE;
                            sync_locked_o  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    sync_locked_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
